// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_sequencer
// Purpose  : Periodic ADC CONV strobe, peak capture with threshold discharge,
//            and valid/ready hand-off of the captured sample.
// Revision : 1.0  initial release
// ============================================================================
module conv_sequencer #(
  parameter int         HIGH_CYCLES   = 70,
  parameter int         PERIOD_CYCLES = 1389,
  parameter int         CONV_LAT      = 100,
  parameter logic [9:0] VREF          = 10'd392,
  parameter int         DISCH_CYCLES  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic [9:0]  i_adc_data,
  output logic        o_conv,
  output logic        o_peak_reset,
  output logic [9:0]  o_sample,
  output logic        o_over_th,
  output logic        o_sample_valid,
  input  logic        i_sample_ready,
  output logic        o_overrun,
  output logic [15:0] o_sample_count
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PW-1:0] c_last      = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] c_high      = PW'(HIGH_CYCLES);
  localparam logic [PW-1:0] c_lat       = PW'(CONV_LAT);
  localparam logic [PW-1:0] c_disch_end = PW'(CONV_LAT + DISCH_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_pcnt;
  logic           r_conv;
  logic           r_peak_reset;
  logic [9:0]     r_sample;
  logic           r_over_th;
  logic           r_sample_valid;
  logic           r_overrun;
  logic [15:0]    r_sample_count;

  state_t         w_next_state;
  logic [PW-1:0]  w_next_pcnt;
  logic           w_capture;
  logic           w_accept;
  logic           w_over;
  logic           w_disch;

  always_comb begin
    w_next_state = r_state;
    w_next_pcnt  = r_pcnt;
    case (r_state)
      S_IDLE: begin
        w_next_pcnt = '0;
        if (i_enable) w_next_state = S_RUN;
      end
      S_RUN: begin
        // enable is only looked at on the last count so a period always completes
        if (r_pcnt == c_last) begin
          w_next_pcnt = '0;
          if (!i_enable) w_next_state = S_IDLE;
        end else begin
          w_next_pcnt = r_pcnt + PW'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_pcnt  = '0;
      end
    endcase
  end

  assign w_capture = (r_state == S_RUN) && (r_pcnt == c_lat);
  assign w_accept  = r_sample_valid && i_sample_ready;
  assign w_over    = (i_adc_data > VREF);
  // Discharge decision follows the sample captured in the current period
  assign w_disch   = w_capture ? w_over : r_over_th;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pcnt         <= '0;
      r_conv         <= 1'b0;
      r_peak_reset   <= 1'b0;
      r_sample       <= '0;
      r_over_th      <= 1'b0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_sample_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pcnt       <= w_next_pcnt;
      r_conv       <= (w_next_state == S_RUN) && (w_next_pcnt < c_high);
      r_peak_reset <= (w_next_state == S_RUN) && (w_next_pcnt > c_lat) &&
                      (w_next_pcnt <= c_disch_end) && w_disch;

      if ((r_state == S_IDLE) && i_enable) r_overrun <= 1'b0;

      if (w_capture) begin
        r_sample       <= i_adc_data;
        r_over_th      <= w_over;
        r_sample_count <= r_sample_count + 16'd1;
        r_sample_valid <= 1'b1;
        if (r_sample_valid && !i_sample_ready) r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  assign o_conv         = r_conv;
  assign o_peak_reset   = r_peak_reset;
  assign o_sample       = r_sample;
  assign o_over_th      = r_over_th;
  assign o_sample_valid = r_sample_valid;
  assign o_overrun      = r_overrun;
  assign o_sample_count = r_sample_count;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_sequencer
// Purpose  : Scoreboard bench for conv_sequencer against a period-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_sequencer;

  localparam int HIGH  = 70;
  localparam int PER   = 1389;
  localparam int LAT   = 100;
  localparam int DISCH = 15;
  localparam int VREF  = 392;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        ready  = 1'b0;
  logic [9:0]  adc    = '0;
  logic        o_conv, o_peak_reset, o_over_th, o_sample_valid, o_overrun;
  logic [9:0]  o_sample;
  logic [15:0] o_sample_count;

  conv_sequencer #(
    .HIGH_CYCLES  (HIGH),
    .PERIOD_CYCLES(PER),
    .CONV_LAT     (LAT),
    .VREF         (10'(VREF)),
    .DISCH_CYCLES (DISCH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (enable),
    .i_adc_data    (adc),
    .o_conv        (o_conv),
    .o_peak_reset  (o_peak_reset),
    .o_sample      (o_sample),
    .o_over_th     (o_over_th),
    .o_sample_valid(o_sample_valid),
    .i_sample_ready(ready),
    .o_overrun     (o_overrun),
    .o_sample_count(o_sample_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_offset = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: position within the period, run flag, and the held sample.
  typedef struct {
    int val;
    bit over;
  } smp_t;

  smp_t q[$];
  smp_t m_new;
  bit   m_run     = 1'b0;
  int   m_pos     = 0;
  int   m_caps    = 0;
  bit   m_disch   = 1'b0;
  bit   m_overrun = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_run = 1'b0; m_pos = 0; m_caps = 0; m_disch = 1'b0; m_overrun = 1'b0;
      q.delete();
    end else begin
      if (m_run && m_pos == LAT) begin
        m_new.val  = int'(adc);
        m_new.over = (int'(adc) > VREF);
        if (q.size() > 0) begin
          m_overrun = 1'b1;
          q.delete();
        end
        q.push_back(m_new);
        m_caps++;
        m_disch = m_new.over;
      end
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1; m_pos = 0; m_overrun = 1'b0;
        end
      end else if (m_pos == PER - 1) begin
        m_pos = 0;
        if (!enable) m_run = 1'b0;
      end else begin
        m_pos++;
      end
    end
  end

  // Monitor: compares every cycle and retires the expected sample on acceptance.
  initial forever begin
    @(negedge clk);
    #2;
    check("conv", o_conv, int'(m_run && m_pos < HIGH));
    check("peak_reset", o_peak_reset,
          int'(m_run && m_pos > LAT && m_pos <= LAT + DISCH && m_disch));
    check("sample_valid", o_sample_valid, int'(q.size() > 0));
    check("overrun", o_overrun, int'(m_overrun));
    check("sample_count", o_sample_count, (m_caps + cnt_offset) & 32'hFFFF);
    if (o_sample_valid && ready && !reset) begin
      check("accept_has_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        check("accepted_sample", o_sample, q[0].val);
        check("accepted_over_th", o_over_th, int'(q[0].over));
        void'(q.pop_front());
      end
    end else if (q.size() > 0) begin
      check("held_sample", o_sample, q[0].val);
      check("held_over_th", o_over_th, int'(q[0].over));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(m_run && m_pos == p) && n < 3 * PER);
    if (!(m_run && m_pos == p)) check("wait_pos_timeout", m_pos, p);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_run && n < 3 * PER) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (m_run) check("wait_idle_timeout", int'(m_run), 0);
  endtask

  task automatic wait_sig(input int sel, input bit lvl, output int at);
    int  n = 0;
    logic cur;
    do begin
      @(negedge clk);
      #1;
      n++;
      cur = (sel == 0) ? o_conv : (sel == 1) ? o_sample_valid : o_peak_reset;
    end while (cur !== lvl && n < 3 * PER);
    at = cyc;
    if (cur !== lvl) check($sformatf("wait_sig%0d_timeout", sel), int'(cur), int'(lvl));
  endtask

  int t0, r1, f1, v1, v0, r2, p1, p0;

  initial begin
    step(3);
    reset = 1'b0;
    step(2);

    // Asynchronous reset while CONV is high, then during discharge
    enable = 1'b1; adc = 10'd908; ready = 1'b0;
    wait_pos(30);
    check("conv_before_reset", o_conv, 1);
    reset = 1'b1;
    #1;
    check("conv_async_reset", o_conv, 0);
    step(2);
    reset = 1'b0;
    wait_pos(LAT + 5);
    check("peak_before_reset", o_peak_reset, 1);
    check("valid_before_reset", o_sample_valid, 1);
    reset = 1'b1; enable = 1'b0;
    #1;
    check("peak_async_reset", o_peak_reset, 0);
    check("valid_async_reset", o_sample_valid, 0);
    check("sample_async_reset", o_sample, 0);
    check("over_th_async_reset", o_over_th, 0);
    check("overrun_async_reset", o_overrun, 0);
    check("count_async_reset", o_sample_count, 0);
    step(2);
    reset = 1'b0;
    step(3000);
    check("idle_count", o_sample_count, 0);
    check("idle_conv", o_conv, 0);

    // Periodic strobe and below-threshold samples
    ready = 1'b1; adc = 10'd136;
    t0 = cyc;
    enable = 1'b1;
    wait_sig(0, 1'b1, r1);
    check("conv_first_rise_latency", r1 - t0, 1);
    wait_sig(0, 1'b0, f1);
    check("conv_high_width", f1 - r1, HIGH);
    wait_sig(1, 1'b1, v1);
    check("valid_after_conv_rise", v1 - r1, LAT + 1);
    check("sample_136", o_sample, 136);
    check("over_th_136", o_over_th, 0);
    wait_sig(1, 1'b0, v0);
    check("valid_pulse_width", v0 - v1, 1);
    wait_sig(0, 1'b1, r2);
    check("conv_period", r2 - r1, PER);

    // Above threshold
    adc = 10'd908;
    wait_sig(2, 1'b1, p1);
    check("peak_start_offset", p1 - r2, LAT + 1);
    check("over_th_908", o_over_th, 1);
    wait_sig(2, 1'b0, p0);
    check("peak_width", p0 - p1, DISCH);

    // Threshold boundaries
    adc = 10'd392;
    wait_pos(LAT + 1);
    check("sample_392", o_sample, 392);
    check("over_th_392", o_over_th, 0);
    check("peak_392", o_peak_reset, 0);
    adc = 10'd393;
    wait_pos(LAT + 1);
    check("over_th_393", o_over_th, 1);
    check("peak_393", o_peak_reset, 1);

    // Backpressure across two captures
    wait_pos(LAT + 3);
    ready = 1'b0; adc = 10'd136;
    wait_pos(LAT + 1);
    check("bp_first_sample", o_sample, 136);
    check("bp_first_overrun", o_overrun, 0);
    adc = 10'd650;
    wait_pos(LAT + 1);
    check("bp_second_sample", o_sample, 650);
    check("bp_valid", o_sample_valid, 1);
    check("bp_overrun", o_overrun, 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("valid_after_ready_pulse", o_sample_valid, 0);

    // Enable drop completes the period; re-enable clears overrun
    wait_pos(200);
    enable = 1'b0;
    wait_idle();
    check("idle_conv_after_drop", o_conv, 0);
    check("idle_overrun_kept", o_overrun, 1);
    check("idle_sample_kept", o_sample, 650);
    step(5);
    enable = 1'b1;
    step(2);
    check("overrun_cleared", o_overrun, 0);

    // Ready exactly on the capture cycle
    wait_pos(LAT + 1);
    check("roc_valid_held", o_sample_valid, 1);
    adc = 10'd77;
    wait_pos(LAT);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("roc_overrun", o_overrun, 0);
    check("roc_valid", o_sample_valid, 1);
    check("roc_sample", o_sample, 77);
    ready = 1'b1;

    // Count wrap from 65535 to 0
    wait_pos(300);
    force dut.r_sample_count = 16'hFFFE;
    cnt_offset = 32'hFFFE - m_caps;
    step(1);
    release dut.r_sample_count;
    wait_pos(LAT + 1);
    check("count_65535", o_sample_count, 65535);
    wait_pos(LAT + 1);
    check("count_wrap_0", o_sample_count, 0);

    // Randomized traffic
    repeat (12 * PER) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 99) < 5) begin
        case ($urandom_range(0, 4))
          0: adc = 10'd392;
          1: adc = 10'd393;
          2: adc = 10'd0;
          3: adc = 10'd1023;
          default: adc = 10'($urandom_range(0, 1023));
        endcase
      end
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2999) == 0) enable = !enable;
    end
    enable = 1'b0;
    wait_idle();
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: reached cycle %0d, expected finish before 80000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/conv_sequencer.md
# conv_sequencer

Initiator side of the peak-detector conversion interface. It generates the periodic CONV strobe for the external ADC and captures the 10-bit peak sample after a fixed conversion latency. It compares the sample against the comparator reference and drives the peak-hold discharge pulse when the threshold is exceeded. It sits between the analog front end (ADC plus peak holder) and the downstream sample consumer, and hands samples off through a valid/ready handshake.

## Interface
Parameters:
- HIGH_CYCLES, 70: CONV high width in clk cycles (1.4 us at 50 MHz).
- PERIOD_CYCLES, 1389: CONV period in clk cycles (about 36 kHz at 50 MHz).
- CONV_LAT, 100: period count at which adc_data is captured.
- VREF, 392: 10-bit threshold. A sample strictly greater than VREF is over threshold.
- DISCH_CYCLES, 15: peak_reset pulse width in cycles.
- Legal range: 1 <= HIGH_CYCLES < PERIOD_CYCLES, and CONV_LAT + DISCH_CYCLES + 1 < PERIOD_CYCLES.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  run request; sampled only in IDLE and at period end.
- adc_data  in  10  ADC result (Vpeak); stable when pcnt == CONV_LAT.
- CONV  out  1  conversion strobe to the ADC.
- peak_reset  out  1  peak-holder discharge pulse.
- sample  out  10  last captured adc_data.
- over_th  out  1  (sample > VREF) for the held sample.
- sample_valid  out  1  sample available.
- sample_ready  in  1  consumer accepts when sample_valid && sample_ready.
- overrun  out  1  sticky: an unaccepted sample was overwritten.
- sample_count  out  16  number of captures; wraps at 65535 -> 0.

## Operation
- States: IDLE and RUN.
- A period counter, pcnt, counts 0..PERIOD_CYCLES-1 in RUN. It is held at 0 in IDLE.
- IDLE -> RUN: enable high in IDLE. The next cycle has pcnt = 0.
- RUN, pcnt == PERIOD_CYCLES-1:
  - enable high: pcnt wraps to 0 and the block stays in RUN.
  - enable low: go to IDLE.
- A deasserted enable never truncates a period.
- CONV = RUN && pcnt < HIGH_CYCLES. It is driven from a register and is glitch-free.
- Capture happens in a RUN cycle with pcnt == CONV_LAT:
  - sample <= adc_data.
  - over_th <= (adc_data > VREF), as an unsigned 10-bit compare.
  - sample_count increments.
  - sample_valid <= 1.
- Discharge:
  - Applies only if the captured value is > VREF.
  - peak_reset is high for exactly DISCH_CYCLES cycles, starting the cycle after capture.
  - Otherwise peak_reset stays low for the whole period.
- Handshake:
  - sample_valid stays high, and sample/over_th stay stable, until a cycle with sample_ready high.
  - sample_valid falls the cycle after acceptance.
  - sample_ready while sample_valid is low has no effect.
- Simultaneous capture and accept (same cycle): the old sample is consumed, the new sample loads, sample_valid stays 1, and no overrun.
- Capture while sample_valid = 1 and sample_ready = 0: the new sample overwrites the held one and overrun <= 1.
- overrun clears only on reset or on the IDLE -> RUN transition.
- Leaving RUN for IDLE does not clear sample, sample_valid or sample_count.

## Timing
- Reset values: CONV, peak_reset, sample_valid, over_th and overrun are 0; sample and sample_count are 0; state is IDLE and pcnt is 0.
- Reset takes effect immediately, including mid-period or mid-discharge: CONV and peak_reset drop without waiting for a clock edge.
- CONV rises 1 cycle after enable is first sampled high in IDLE. It stays high HIGH_CYCLES cycles, and rising edges are exactly PERIOD_CYCLES apart.
- sample, over_th and sample_valid update in the cycle after the pcnt == CONV_LAT edge. The capture latency from the CONV rise is CONV_LAT + 1 cycles.
- peak_reset is high while pcnt is in CONV_LAT+1 .. CONV_LAT+DISCH_CYCLES. It always ends before the next CONV rise.

## Test plan
- Reset and idle:
  - Assert reset mid-run.
  - Required: all outputs are 0 immediately.
  - Release reset with enable = 0 for 3000 cycles: CONV stays 0 and sample_count stays 0.
- Periodic strobe:
  - Hold enable = 1 with default parameters.
  - CONV rises 1 cycle after enable, is high 70 cycles, and rises every 1389 cycles.
  - sample_valid rises 101 cycles after each CONV rise.
- Below threshold:
  - Drive adc_data = 10'b0010001000 (136) with sample_ready = 1.
  - sample = 136, over_th = 0, peak_reset never asserts.
  - sample_valid pulses 1 cycle per period.
- Above threshold:
  - adc_data = 10'b1110001100 (908): over_th = 1 and peak_reset is high exactly 15 cycles, pcnt 101..115.
  - Boundaries: adc_data = 392 gives no discharge; adc_data = 393 gives discharge.
- Backpressure:
  - Hold sample_ready = 0 across two captures (136, then 650).
  - sample = 650, sample_valid = 1, overrun = 1.
  - A one-cycle ready pulse drops sample_valid.
  - Ready asserted exactly on a capture cycle gives no overrun.
- Enable drop and wrap:
  - Deassert enable at pcnt = 200: the period completes, then IDLE with CONV = 0.
  - Re-enable: overrun clears.
  - Preload or run so that sample_count goes from 65535 to 0 on the next capture.
